if_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register.
- Issues sequential fetches to a variable-latency instruction memory using a req/ack handshake.
- Buffers the returned instructions with their PCs in a DEPTH-entry FIFO and presents them to IF/ID through a valid/ready interface.
- Flushes the FIFO and discards any in-flight fetch when the MEM-stage branch redirects the PC.

---
 rtl/if_prefetch_queue.sv | 116 +++++++++++
 tb/tb_if_prefetch_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential req/ack fetches, buffers
// {pc, instr} in a small FIFO and hands them to IF/ID over valid/ready.
//
// state | meaning
// IDLE  | no memory request outstanding
// WAIT  | request outstanding, returned data will be pushed
// DROP  | request outstanding, returned data discarded after a redirect
module if_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_next;

    logic ack, push, pop, slot_free, issue;

    assign ack        = req_q & mem_ack_i;
    assign push       = (state_q == WAIT) & ack;
    assign pop        = (count != '0) & instr_ready_i;
    assign count_next = count + CW'(push) - CW'(pop);
    assign slot_free  = (state_q == IDLE) | ack;
    // One slot is always held back for the request that is about to be issued.
    assign issue      = slot_free & (count_next < CW'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
            if (slot_free) begin
                state_d = IDLE;
                req_d   = 1'b0;
            end else begin
                state_d = DROP;
            end
        end else if (issue) begin
            state_d    = WAIT;
            req_d      = 1'b1;
            addr_d     = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (slot_free) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count_next;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !redirect_i && push) begin
            instr_mem[wr_ptr] <= mem_rdata_i;
            pc_mem[wr_ptr]    <= addr_q;
        end
    end

    assign mem_req_o     = req_q;
    assign mem_addr_o    = addr_q;
    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? instr_mem[rd_ptr] : 32'd0;
    assign pc_o          = instr_valid_o ? pc_mem[rd_ptr]    : 32'd0;
    assign pc_next_o     = instr_valid_o ? pc_o + 32'd4      : 32'd0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: memory model returns addr>>2 after a
// programmable number of wait cycles.
module tb_if_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready = 1'b1;
    int          lat = 0;
    int          wait_cnt = 0;

    logic        req0, valid0, ack0;
    logic [31:0] addr0, rdata0, instr0, pc0, pcn0;
    logic        req1, valid1, ack1;
    logic [31:0] addr1, rdata1, instr1, pc1, pcn1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign ack0   = req0 && (wait_cnt >= lat);
    assign rdata0 = addr0 >> 2;
    assign ack1   = req1;
    assign rdata1 = addr1 >> 2;

    always @(posedge clk) begin
        if (rst)               wait_cnt <= 0;
        else if (req0 && !ack0) wait_cnt <= wait_cnt + 1;
        else                   wait_cnt <= 0;
    end

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .mem_req_o(req0), .mem_addr_o(addr0), .mem_ack_i(ack0), .mem_rdata_i(rdata0),
        .instr_valid_o(valid0), .instr_ready_i(ready), .instr_o(instr0),
        .pc_o(pc0), .pc_next_o(pcn0)
    );

    if_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .redirect_i(1'b0), .redirect_pc_i(32'd0),
        .mem_req_o(req1), .mem_addr_o(addr1), .mem_ack_i(ack1), .mem_rdata_i(rdata1),
        .instr_valid_o(valid1), .instr_ready_i(ready), .instr_o(instr1),
        .pc_o(pc1), .pc_next_o(pcn1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: reset just sampled, next edge is the first live one.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state and zero-wait streaming
        lat = 0; ready = 1'b1;
        do_reset();
        chk("rst_req", {31'd0, req0}, 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_valid", {31'd0, valid0}, 32'd0);
        chk("rst_instr", instr0, 32'd0);
        chk("rst_pc", pc0, 32'd0);
        chk("rst_pcnext", pcn0, 32'd0);
        chk("wrap_rst_req", {31'd0, req1}, 32'd0);
        tick();
        chk("zw_c1_req", {31'd0, req0}, 32'd1);
        chk("zw_c1_addr", addr0, 32'd0);
        chk("zw_c1_valid", {31'd0, valid0}, 32'd0);
        chk("wrap_c1_addr", addr1, 32'hFFFF_FFF8);
        tick();
        chk("wrap_c2_addr", addr1, 32'hFFFF_FFFC);
        chk("wrap_c2_pc", pc1, 32'hFFFF_FFF8);
        chk("wrap_c2_pcnext", pcn1, 32'hFFFF_FFFC);
        for (int k = 2; k <= 6; k++) begin
            chk("zw_valid", {31'd0, valid0}, 32'd1);
            chk("zw_addr", addr0, 32'(4 * (k - 1)));
            chk("zw_pc", pc0, 32'(4 * (k - 2)));
            chk("zw_pcnext", pcn0, 32'(4 * (k - 1)));
            chk("zw_instr", instr0, 32'(k - 2));
            if (k == 3) begin
                chk("wrap_c3_addr", addr1, 32'h0000_0000);
                chk("wrap_c3_pc", pc1, 32'hFFFF_FFFC);
                chk("wrap_c3_pcnext", pcn1, 32'h0000_0000);
                chk("wrap_c3_instr", instr1, 32'h3FFF_FFFF);
            end
            tick();
        end

        // Stalled consumer fills the FIFO with exactly DEPTH requests
        ready = 1'b0;
        do_reset();
        chk("full_c0_req", {31'd0, req0}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("full_req", {31'd0, req0}, 32'd1);
            chk("full_addr", addr0, 32'(4 * (k - 1)));
        end
        tick();
        chk("full_c5_req", {31'd0, req0}, 32'd0);
        chk("full_c5_pc", pc0, 32'd0);
        tick();
        chk("full_c6_req", {31'd0, req0}, 32'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("full_c7_req", {31'd0, req0}, 32'd1);
        chk("full_c7_addr", addr0, 32'h10);
        chk("full_c7_pc", pc0, 32'h4);
        tick();
        chk("full_c8_req", {31'd0, req0}, 32'd0);
        chk("full_c8_pc", pc0, 32'h4);

        // Redirect while a slow fetch is outstanding
        lat = 2; ready = 1'b1;
        do_reset();
        repeat (4) tick();
        chk("lat_c4_addr", addr0, 32'h4);
        chk("lat_c4_pc", pc0, 32'h0);
        repeat (3) tick();
        chk("lat_c7_addr", addr0, 32'h8);
        chk("lat_c7_pc", pc0, 32'h4);
        tick();
        chk("lat_c8_ack", {31'd0, ack0}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk("drop_c9_valid", {31'd0, valid0}, 32'd0);
        chk("drop_c9_req", {31'd0, req0}, 32'd1);
        chk("drop_c9_addr", addr0, 32'h8);
        tick();
        chk("drop_c10_addr", addr0, 32'h100);
        chk("drop_c10_valid", {31'd0, valid0}, 32'd0);
        tick();
        chk("drop_c11_valid", {31'd0, valid0}, 32'd0);
        tick();
        chk("drop_c12_valid", {31'd0, valid0}, 32'd0);
        tick();
        chk("drop_c13_valid", {31'd0, valid0}, 32'd1);
        chk("drop_c13_pc", pc0, 32'h100);
        chk("drop_c13_instr", instr0, 32'h40);

        // Redirect coinciding with ack and pop
        lat = 0; ready = 1'b1;
        do_reset();
        repeat (3) tick();
        chk("rda_c3_addr", addr0, 32'h8);
        chk("rda_c3_pc", pc0, 32'h4);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk("rda_c4_valid", {31'd0, valid0}, 32'd0);
        chk("rda_c4_req", {31'd0, req0}, 32'd0);
        tick();
        chk("rda_c5_req", {31'd0, req0}, 32'd1);
        chk("rda_c5_addr", addr0, 32'h40);
        chk("rda_c5_valid", {31'd0, valid0}, 32'd0);
        tick();
        chk("rda_c6_pc", pc0, 32'h40);
        chk("rda_c6_instr", instr0, 32'h10);

        // Reset while in DROP
        lat = 2; ready = 1'b1;
        do_reset();
        tick();
        chk("rdrop_c1_req", {31'd0, req0}, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("rdrop_c2_req", {31'd0, req0}, 32'd1);
        chk("rdrop_c2_addr", addr0, 32'h0);
        rst = 1'b1;
        tick();
        chk("rdrop_c3_req", {31'd0, req0}, 32'd0);
        chk("rdrop_c3_valid", {31'd0, valid0}, 32'd0);
        chk("rdrop_c3_addr", addr0, 32'h0);
        rst = 1'b0;
        tick();
        chk("rdrop_c4_req", {31'd0, req0}, 32'd1);
        chk("rdrop_c4_addr", addr0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
